// File: rtl/ir_prefetch_pkg.sv
// Shared constants for the instruction register / prefetch queue slice.
package ir_prefetch_pkg;
  localparam int unsigned IR_WIDTH    = 8;
  localparam int unsigned IR_DEPTH    = 4;
  localparam logic [7:0]  IR_RESET_OP = 8'h00;  // BRK
endpackage

// File: rtl/ir_prefetch_if.sv
// Predecode-to-decoder bus: fetch/advance/flush controls in, IR and queue status out.
interface ir_prefetch_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] n_PD;
  logic             FETCH;
  logic             NEXT;
  logic             FLUSH;
  logic [WIDTH-1:0] IR;
  logic             IR_VALID;
  logic [CW-1:0]    COUNT;
  logic             FULL;
  logic             EMPTY;
  logic             OVF;

  modport master (
    output n_PD, FETCH, NEXT, FLUSH,
    input  IR, IR_VALID, COUNT, FULL, EMPTY, OVF
  );
  modport slave (
    input  n_PD, FETCH, NEXT, FLUSH,
    output IR, IR_VALID, COUNT, FULL, EMPTY, OVF
  );
endinterface

// File: rtl/ir_queue.sv
// Circular prefetch buffer; any DEPTH >= 1, pointers wrap explicitly at DEPTH-1.
module ir_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wp, rp;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage needs no reset: COUNT gates what is visible.
  always_ff @(posedge CLK)
    if (push) mem[wp] <= wdata;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= inc(wp);
      if (pop)  rp <= inc(rp);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rp];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/ir_prefetch.sv
// Instruction register fed by a prefetch queue, with empty-queue bypass and sticky overflow.
module ir_prefetch
  import ir_prefetch_pkg::*;
#(
  parameter int unsigned    WIDTH    = IR_WIDTH,
  parameter int unsigned    DEPTH    = IR_DEPTH,
  parameter logic [WIDTH-1:0] RESET_OP = WIDTH'(IR_RESET_OP),
  parameter bit             INV_IN   = 1'b1
) (
  input logic CLK,
  input logic RST,
  ir_prefetch_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] d, head, ir_q;
  logic             ir_vld_q, ovf_q;
  logic [CW-1:0]    count;
  logic             full, empty;
  logic             take, deq, bypass, want_push, push, drop;

  assign d = INV_IN ? ~bus.n_PD : bus.n_PD;

  // FLUSH masks every queue action; IR_VALID is cleared separately below.
  always_comb begin
    take      = bus.NEXT | ~ir_vld_q;
    deq       = take & ~empty & ~bus.FLUSH;
    bypass    = take & empty & bus.FETCH;
    want_push = bus.FETCH & ~bypass & ~bus.FLUSH;
    push      = want_push & (~full | deq);
    drop      = want_push & full & ~deq;
  end

  ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_queue (
    .CLK   (CLK),
    .RST   (RST),
    .flush (bus.FLUSH),
    .push  (push),
    .pop   (deq),
    .wdata (d),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ir_q     <= RESET_OP;
      ir_vld_q <= 1'b0;
    end else if (bus.FLUSH) begin
      ir_vld_q <= 1'b0;
    end else if (take) begin
      if (!empty) begin
        ir_q     <= head;
        ir_vld_q <= 1'b1;
      end else if (bus.FETCH) begin
        ir_q     <= d;
        ir_vld_q <= 1'b1;
      end else begin
        ir_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign bus.IR       = ir_q;
  assign bus.IR_VALID = ir_vld_q;
  assign bus.COUNT    = count;
  assign bus.FULL     = full;
  assign bus.EMPTY    = empty;
  assign bus.OVF      = ovf_q;
endmodule

// File: tb/tb_ir_prefetch.sv
// Directed bench for ir_prefetch (WIDTH=8, DEPTH=4, INV_IN=1).
module tb_ir_prefetch;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  ir_prefetch_if #(.WIDTH(8), .DEPTH(4)) bus ();

  ir_prefetch #(.WIDTH(8), .DEPTH(4), .RESET_OP(8'h00), .INV_IN(1'b1)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  // Drive controls at negedge, let one posedge happen, sample 1 time unit later.
  task automatic cyc(input logic f, input logic n, input logic fl, input logic [7:0] pd);
    @(negedge CLK);
    bus.FETCH = f; bus.NEXT = n; bus.FLUSH = fl; bus.n_PD = pd;
    @(posedge CLK);
    #1;
    bus.FETCH = 1'b0; bus.NEXT = 1'b0; bus.FLUSH = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    bus.FETCH = 1'b0; bus.NEXT = 1'b0; bus.FLUSH = 1'b0; bus.n_PD = 8'hff;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.IR !== 8'h00)      begin n_bad++; $display("FAIL reset_ir got %h want 00", bus.IR); end
    n_cmp++; if (bus.IR_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", bus.IR_VALID); end
    n_cmp++; if (bus.COUNT !== 3'd0)    begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.COUNT); end
    n_cmp++; if (bus.EMPTY !== 1'b1 || bus.FULL !== 1'b0 || bus.OVF !== 1'b0)
      begin n_bad++; $display("FAIL reset_flags got e%b f%b o%b want e1 f0 o0", bus.EMPTY, bus.FULL, bus.OVF); end
  endtask

  task automatic test_bypass();
    cyc(1, 0, 0, 8'ha5);
    n_cmp++; if (bus.IR !== 8'h5a)      begin n_bad++; $display("FAIL bypass_ir got %h want 5a", bus.IR); end
    n_cmp++; if (bus.IR_VALID !== 1'b1) begin n_bad++; $display("FAIL bypass_vld got %b want 1", bus.IR_VALID); end
    n_cmp++; if (bus.EMPTY !== 1'b1)    begin n_bad++; $display("FAIL bypass_empty got %b want 1", bus.EMPTY); end
  endtask

  task automatic test_queue();
    logic [7:0] pd [3] = '{8'hfe, 8'hfd, 8'hfc};
    logic [7:0] ex [3] = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, pd[i]);
    n_cmp++; if (bus.COUNT !== 3'd3) begin n_bad++; $display("FAIL queue_count got %0d want 3", bus.COUNT); end
    n_cmp++; if (bus.IR !== 8'h5a)   begin n_bad++; $display("FAIL queue_ir_hold got %h want 5a", bus.IR); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 8'h00);
      n_cmp++; if (bus.IR !== ex[i] || bus.IR_VALID !== 1'b1 || bus.COUNT !== 3'(2 - i))
        begin n_bad++; $display("FAIL queue_next%0d got ir=%h v=%b c=%0d want ir=%h v=1 c=%0d",
                                i, bus.IR, bus.IR_VALID, bus.COUNT, ex[i], 2 - i); end
    end
    cyc(0, 1, 0, 8'h00);
    n_cmp++; if (bus.IR_VALID !== 1'b0 || bus.IR !== 8'h03)
      begin n_bad++; $display("FAIL queue_drain got v=%b ir=%h want v=0 ir=03", bus.IR_VALID, bus.IR); end
    // NEXT with nothing in IR acts as a plain take: FETCH bypasses straight in
    cyc(1, 1, 0, 8'h3c);
    n_cmp++; if (bus.IR !== 8'hc3 || bus.IR_VALID !== 1'b1 || bus.COUNT !== 3'd0)
      begin n_bad++; $display("FAIL queue_take_idle got ir=%h v=%b c=%0d want ir=c3 v=1 c=0", bus.IR, bus.IR_VALID, bus.COUNT); end
  endtask

  task automatic test_overflow();
    do_reset();
    cyc(1, 0, 0, ~8'h10);
    for (int i = 1; i <= 5; i++) cyc(1, 0, 0, ~(8'h10 + 8'(i)));
    n_cmp++; if (bus.COUNT !== 3'd4 || bus.FULL !== 1'b1 || bus.OVF !== 1'b1)
      begin n_bad++; $display("FAIL ovf_fill got c=%0d f=%b o=%b want c=4 f=1 o=1", bus.COUNT, bus.FULL, bus.OVF); end
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 0, 8'h00);
      n_cmp++; if (bus.IR !== 8'h10 + 8'(i) || bus.OVF !== 1'b1)
        begin n_bad++; $display("FAIL ovf_drain%0d got ir=%h o=%b want ir=%h o=1", i, bus.IR, bus.OVF, 8'h10 + 8'(i)); end
    end
    n_cmp++; if (bus.EMPTY !== 1'b1) begin n_bad++; $display("FAIL ovf_dropped got empty=%b want 1", bus.EMPTY); end
    do_reset();
    n_cmp++; if (bus.OVF !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %b want 0", bus.OVF); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1, 0, 0, ~8'h20);
    for (int i = 1; i <= 4; i++) cyc(1, 0, 0, ~(8'h20 + 8'(i)));
    n_cmp++; if (bus.FULL !== 1'b1 || bus.OVF !== 1'b0)
      begin n_bad++; $display("FAIL b2b_full got f=%b o=%b want f=1 o=0", bus.FULL, bus.OVF); end
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, ~(8'h25 + 8'(i)));
      n_cmp++; if (bus.IR !== 8'h21 + 8'(i) || bus.COUNT !== 3'd4 || bus.OVF !== 1'b0)
        begin n_bad++; $display("FAIL b2b_%0d got ir=%h c=%0d o=%b want ir=%h c=4 o=0",
                                i, bus.IR, bus.COUNT, bus.OVF, 8'h21 + 8'(i)); end
    end
  endtask

  task automatic test_flush();
    // IR=2a, queue 2b..2e; two NEXTs leave IR=2c with two entries queued
    cyc(0, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    n_cmp++; if (bus.IR !== 8'h2c || bus.COUNT !== 3'd2)
      begin n_bad++; $display("FAIL flush_pre got ir=%h c=%0d want ir=2c c=2", bus.IR, bus.COUNT); end
    cyc(1, 1, 1, 8'h77);
    n_cmp++; if (bus.COUNT !== 3'd0 || bus.IR_VALID !== 1'b0 || bus.IR !== 8'h2c || bus.EMPTY !== 1'b1)
      begin n_bad++; $display("FAIL flush got c=%0d v=%b ir=%h e=%b want c=0 v=0 ir=2c e=1",
                              bus.COUNT, bus.IR_VALID, bus.IR, bus.EMPTY); end
    cyc(1, 0, 0, 8'h5a);
    n_cmp++; if (bus.IR !== 8'ha5 || bus.IR_VALID !== 1'b1 || bus.COUNT !== 3'd0)
      begin n_bad++; $display("FAIL flush_bypass got ir=%h v=%b c=%0d want ir=a5 v=1 c=0", bus.IR, bus.IR_VALID, bus.COUNT); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(i));
    cyc(0, 1, 0, 8'h00);
    n_cmp++; if (bus.COUNT !== 3'd3 || bus.OVF !== 1'b1)
      begin n_bad++; $display("FAIL areset_pre got c=%0d o=%b want c=3 o=1", bus.COUNT, bus.OVF); end
    #2 RST = 1'b1;
    #1;
    n_cmp++; if (bus.IR !== 8'h00 || bus.COUNT !== 3'd0 || bus.OVF !== 1'b0 || bus.IR_VALID !== 1'b0 || bus.EMPTY !== 1'b1)
      begin n_bad++; $display("FAIL areset got ir=%h c=%0d o=%b v=%b e=%b want ir=00 c=0 o=0 v=0 e=1",
                              bus.IR, bus.COUNT, bus.OVF, bus.IR_VALID, bus.EMPTY); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    bus.FETCH = 1'b0; bus.NEXT = 1'b0; bus.FLUSH = 1'b0; bus.n_PD = 8'hff;
    test_reset();
    test_bypass();
    test_queue();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
